// File: rtl/turbo_enc_ctrl.sv
// Sequencing controller for the rate-1/3 NB-IoT turbo encoder: K data triples, 3-cycle trellis
// termination, then 4 tail triples. Optional sticky start-error flag under `TURBO_ERR_EN`.
module turbo_enc_ctrl #(
    parameter int KMAX = 6144,
    parameter int KW   = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          x,
    input  logic          xi,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          d0,
    output logic          d1,
    output logic          d2,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TERM = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [2:0]    enc1_r, enc2_r;      // {s1, s2, s3}
    logic [KW-1:0] k_r, count_r;
    logic [1:0]    term_r;
    logic [2:0]    tail_cnt_r;
    logic [11:0]   tail_r;              // [11:6] encoder 1 tail bits, [5:0] encoder 2
    logic          out_valid_r, d0_r, d1_r, d2_r, out_last_r, done_r;

    logic          legal_s, out_free_s, in_ready_s, in_fire_s, last_pair_s;
    logic          tail_load_s, last_hs_s;
    logic [3:0]    step1_s, step2_s, tstep1_s, tstep2_s;
    logic          tu1_s, tu2_s;

    // One RSC step: returns {z, next_state}
    function automatic logic [3:0] rsc_step(input logic u, input logic [2:0] s);
        logic a;
        a = u ^ s[1] ^ s[0];
        return {a ^ s[2] ^ s[0], a, s[2], s[1]};
    endfunction

    // Tail input that drives the feedback bit to zero
    function automatic logic tail_in(input logic [2:0] s);
        return s[1] ^ s[0];
    endfunction

    assign legal_s     = (k_len >= KW'(40)) && (k_len <= KW'(KMAX));
    assign out_free_s  = !out_valid_r || out_ready;
    assign in_ready_s  = (state_r == ST_DATA) && out_free_s;
    assign in_fire_s   = in_valid && in_ready_s;
    assign last_pair_s = (count_r == (k_r - KW'(1)));
    assign tail_load_s = (state_r == ST_TAIL) && out_free_s && (tail_cnt_r < 3'd4);
    assign last_hs_s   = (state_r == ST_TAIL) && out_valid_r && out_ready && out_last_r;

    assign step1_s  = rsc_step(x, enc1_r);
    assign step2_s  = rsc_step(xi, enc2_r);
    assign tu1_s    = tail_in(enc1_r);
    assign tu2_s    = tail_in(enc2_r);
    assign tstep1_s = rsc_step(tu1_s, enc1_r);
    assign tstep2_s = rsc_step(tu2_s, enc2_r);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && legal_s) state_s = ST_DATA;
                else                  state_s = ST_IDLE;
            end
            ST_DATA: begin
                if (in_fire_s && last_pair_s) state_s = ST_TERM;
                else                          state_s = ST_DATA;
            end
            ST_TERM: begin
                if (term_r == 2'd2) state_s = ST_TAIL;
                else                state_s = ST_TERM;
            end
            ST_TAIL: begin
                if (last_hs_s) state_s = ST_IDLE;
                else           state_s = ST_TAIL;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Encoder states, counters and tail capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc1_r     <= 3'd0;
            enc2_r     <= 3'd0;
            k_r        <= KW'(0);
            count_r    <= KW'(0);
            term_r     <= 2'd0;
            tail_cnt_r <= 3'd0;
            tail_r     <= 12'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && legal_s) begin
                        k_r        <= k_len;
                        count_r    <= KW'(0);
                        enc1_r     <= 3'd0;
                        enc2_r     <= 3'd0;
                        term_r     <= 2'd0;
                        tail_cnt_r <= 3'd0;
                        tail_r     <= 12'd0;
                    end
                end
                ST_DATA: begin
                    if (in_fire_s) begin
                        enc1_r  <= step1_s[2:0];
                        enc2_r  <= step2_s[2:0];
                        count_r <= count_r + KW'(1);
                    end
                end
                ST_TERM: begin
                    enc1_r <= tstep1_s[2:0];
                    enc2_r <= tstep2_s[2:0];
                    tail_r <= {tail_r[9:6], tu1_s, tstep1_s[3], tail_r[3:0], tu2_s, tstep2_s[3]};
                    term_r <= term_r + 2'd1;
                end
                ST_TAIL: begin
                    if (tail_load_s) begin
                        tail_r     <= {tail_r[8:0], 3'b000};
                        tail_cnt_r <= tail_cnt_r + 3'd1;
                    end
                end
                default: begin
                    term_r <= 2'd0;
                end
            endcase
        end
    end

    // Single-stage output register; data triples take priority over tail triples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            d0_r        <= 1'b0;
            d1_r        <= 1'b0;
            d2_r        <= 1'b0;
            out_last_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= last_hs_s;
            if (in_fire_s) begin
                out_valid_r <= 1'b1;
                {d0_r, d1_r, d2_r} <= {x, step1_s[3], step2_s[3]};
                out_last_r  <= 1'b0;
            end else if (tail_load_s) begin
                out_valid_r <= 1'b1;
                {d0_r, d1_r, d2_r} <= tail_r[11:9];
                out_last_r  <= (tail_cnt_r == 3'd3);
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

`ifdef TURBO_ERR_EN
    logic err_r;

    // Sticky flag for starts that arrive while busy or with an out-of-range length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (start && ((state_r != ST_IDLE) || !legal_s)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign d0        = d0_r;
    assign d1        = d1_r;
    assign d2        = d2_r;
    assign out_last  = out_last_r;
    assign busy      = (state_r != ST_IDLE);
    assign done      = done_r;

endmodule

// File: tb/tb_turbo_enc_ctrl.sv
// Self-checking bench for turbo_enc_ctrl: table-driven blocks with a triple scoreboard,
// plus hand-written illegal-start and mid-block reset sequences.
module tb_turbo_enc_ctrl;
    localparam int KW = 13;
`ifdef TURBO_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          in_valid = 1'b0;
    logic          x = 1'b0;
    logic          xi = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, d0, d1, d2, out_last, busy, done, err;

    turbo_enc_ctrl #(.KMAX(6144), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .xi(xi),
        .out_valid(out_valid), .out_ready(out_ready),
        .d0(d0), .d1(d1), .d2(d2), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] sb_q[$];
    logic [2:0] rx_log [0:6199];
    int         rx_cnt = 0;
    bit         mon_en = 1'b0, stall_mode = 1'b0, blk_done = 1'b0;
    bit         done_pend = 1'b0, hold_pend = 1'b0, exp_err = 1'b0;
    logic [2:0] hold_trip = 3'd0;
    logic [2:0] m1 = 3'd0, m2 = 3'd0;

    typedef struct {
        int k;
        int pat;
        bit stall;
        bit ovl;
        int exp_n;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model of one RSC step from the encoder equations: returns {z, s1', s2', s3'}
    function automatic logic [3:0] enc_step(input logic u, input logic [2:0] s);
        logic s1, s2, s3, a;
        s1 = s[2]; s2 = s[1]; s3 = s[0];
        a = u ^ s2 ^ s3;
        return {a ^ s1 ^ s3, a, s1, s2};
    endfunction

    function automatic logic [1:0] pat_bits(input int pat, input int i, input int k);
        case (pat)
            0: return 2'b00;
            1: return (i == k - 1) ? 2'b11 : 2'b00;
            default: return {(((i * 7 + 3) % 5) < 2), 1'(((i * 13) >> 2) & 1)};
        endcase
    endfunction

    task automatic push_tail();
        logic [2:0] xt1, zt1, xt2, zt2;
        logic [3:0] r;
        logic       u;
        for (int j = 0; j < 3; j++) begin
            u = m1[1] ^ m1[0]; r = enc_step(u, m1); xt1[2-j] = u; zt1[2-j] = r[3]; m1 = r[2:0];
            u = m2[1] ^ m2[0]; r = enc_step(u, m2); xt2[2-j] = u; zt2[2-j] = r[3]; m2 = r[2:0];
        end
        sb_q.push_back({xt1[2], zt1[2], xt1[1], 1'b0});
        sb_q.push_back({zt1[1], xt1[0], zt1[0], 1'b0});
        sb_q.push_back({xt2[2], zt2[2], xt2[1], 1'b0});
        sb_q.push_back({zt2[1], xt2[0], zt2[0], 1'b1});
    endtask

    task automatic do_start(input int k);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int k, input int pat, input int n);
        logic [1:0] b;
        logic [3:0] r1, r2;
        int         budget;
        for (int i = 0; i < n; i++) begin
            b = pat_bits(pat, i, k);
            @(posedge clk); #1;
            in_valid = 1'b1; x = b[1]; xi = b[0];
            budget = 0;
            @(negedge clk);
            while (!in_ready && budget < 200) begin
                budget++;
                @(negedge clk);
            end
            if (!in_ready) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout pair=%0d actual=0 expected=1", i);
                in_valid = 1'b0;
                return;
            end
            r1 = enc_step(b[1], m1); m1 = r1[2:0];
            r2 = enc_step(b[0], m2); m2 = r2[2:0];
            sb_q.push_back({b[1], r1[3], r2[3], 1'b0});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (n == k) push_tail();
    endtask

    task automatic wait_done(input int exp_n);
        int cyc = 0;
        while (!blk_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (!blk_done) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=0 expected=1");
        end
        @(negedge clk);
        chk("rx_count", 32'(rx_cnt), 32'(exp_n));
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("err_after", 32'(err), 32'(exp_err));
    endtask

    // Output monitor: scoreboard pops, stall stability, done pulse
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (done || done_pend) begin
                    chk("done_pulse", 32'(done), 32'(done_pend));
                    if (done) blk_done = 1'b1;
                end
                done_pend = 1'b0;
                if (hold_pend) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'({d0, d1, d2}), 32'(hold_trip));
                end
                hold_pend = 1'b0;
                if (out_valid && !out_ready) begin
                    hold_pend = 1'b1;
                    hold_trip = {d0, d1, d2};
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_triple actual=%b%b%b expected=none", d0, d1, d2);
                    end else begin
                        e = sb_q.pop_front();
                        chk("triple", 32'({d0, d1, d2, out_last}), 32'(e));
                        if (rx_cnt < 6200) rx_log[rx_cnt] = {d0, d1, d2};
                        rx_cnt++;
                        if (e[0]) done_pend = 1'b1;
                    end
                end
            end
        end
    end

    // Downstream back-pressure: steady ready or a 1-0-1-0 toggle
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_mode) out_ready = ~out_ready;
            else            out_ready = 1'b1;
        end
    end

    initial begin
        vecs[0] = '{40,   0, 1'b0, 1'b0, 44};
        vecs[1] = '{40,   1, 1'b0, 1'b0, 44};
        vecs[2] = '{40,   1, 1'b1, 1'b0, 44};
        vecs[3] = '{40,   2, 1'b1, 1'b0, 44};
        vecs[4] = '{57,   2, 1'b0, 1'b0, 61};
        vecs[5] = '{40,   0, 1'b0, 1'b1, 44};
        vecs[6] = '{6144, 2, 1'b0, 1'b0, 6148};

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out", 32'({out_valid, d0, d1, d2, out_last}), 32'd0);
        chk("rst_status", 32'({busy, done, err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < 7; v++) begin
            blk_done = 1'b0; rx_cnt = 0; m1 = 3'd0; m2 = 3'd0;
            stall_mode = vecs[v].stall;
            do_start(vecs[v].k);
            chk("busy_start", 32'(busy), 32'd1);
            if (!vecs[v].stall) chk("in_ready_start", 32'(in_ready), 32'd1);
            if (vecs[v].ovl) begin
                exp_err = ERR_ON;
                fork
                    begin
                        repeat (15) @(posedge clk);
                        #1 start = 1'b1; k_len = KW'(40);
                        @(posedge clk);
                        #1 start = 1'b0;
                    end
                join_none
            end
            feed(vecs[v].k, vecs[v].pat, vecs[v].k);
            wait_done(vecs[v].exp_n);
            if (vecs[v].pat == 1) begin
                chk("last_data_triple", 32'(rx_log[vecs[v].k - 1]), 32'b111);
                for (int t = 0; t < 4; t++)
                    chk("tail_triple", 32'(rx_log[vecs[v].k + t]), 32'b011);
            end
            stall_mode = 1'b0;
        end

        // Illegal lengths are ignored
        do_start(39);
        exp_err = ERR_ON;
        @(negedge clk);
        chk("k39_busy", 32'(busy), 32'd0);
        chk("k39_in_ready", 32'(in_ready), 32'd0);
        chk("k39_err", 32'(err), 32'(exp_err));
        do_start(6145);
        @(negedge clk);
        chk("k6145_busy", 32'(busy), 32'd0);
        chk("k6145_in_ready", 32'(in_ready), 32'd0);
        chk("k6145_err", 32'(err), 32'(exp_err));

        // Asynchronous reset after 20 of 40 pairs
        blk_done = 1'b0; rx_cnt = 0; m1 = 3'd0; m2 = 3'd0;
        do_start(40);
        feed(40, 0, 20);
        mon_en = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out", 32'({out_valid, d0, d1, d2, out_last}), 32'd0);
        chk("arst_status", 32'({busy, done, err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 1'b0;
        sb_q.delete();
        hold_pend = 1'b0; done_pend = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_no_done", 32'({busy, done}), 32'd0);
        mon_en = 1'b1;
        blk_done = 1'b0; rx_cnt = 0; m1 = 3'd0; m2 = 3'd0;
        do_start(40);
        feed(40, 0, 40);
        wait_done(44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
